// File: rtl/string_buffer.sv
// Fixed-depth edit line with a cursor, driven by one-cycle key events.
// Insert and backspace ripple the line one slot per cycle while o_ready is low.
module string_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_sclr,
  input  logic [7:0]    i_asciiex,
  input  logic          i_asciiex_en,
  input  logic          i_type,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_dat,
  output logic [AW-1:0] o_len,
  output logic [AW-1:0] o_cursor,
  output logic          o_ready,
  output logic          o_full,
  output logic          o_changed,
  output logic          o_err
);

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam int            SLOTS   = 2 ** AW;

  typedef enum logic [1:0] {IDLE, SHIFT_R, SHIFT_L} state_t;

  state_t        state;
  logic [AW-1:0] len_q;
  logic [AW-1:0] cur_q;
  logic [AW-1:0] idx_q;
  // Sized to the full address space so any AW-bit index is legal; slots at or
  // beyond DEPTH are never written and stay constant zero.
  logic [7:0]    line_mem [SLOTS];

  logic is_ins, is_bs, is_right, is_down, is_left;
  logic known, class_ok, accept, drop, rd_ok;
  logic [7:0] down_src;

  assign is_ins   = (i_asciiex == 8'h41);
  assign is_bs    = (i_asciiex == 8'h08);
  assign is_right = (i_asciiex == 8'h02);
  assign is_down  = (i_asciiex == 8'h03);
  assign is_left  = (i_asciiex == 8'h04);
  assign known    = is_ins | is_bs | is_right | is_down | is_left;
  assign class_ok = (is_ins | is_bs) ? i_type : ~i_type;
  assign accept   = i_asciiex_en & o_ready & known & class_ok;
  assign drop     = i_asciiex_en & ~accept;
  assign rd_ok    = (i_rd_addr < DEPTH_A);
  assign down_src = line_mem[cur_q - ONE_A];

  assign o_ready  = (state == IDLE);
  assign o_len    = len_q;
  assign o_cursor = cur_q;
  assign o_full   = (len_q == DEPTH_A);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      cur_q     <= '0;
      idx_q     <= '0;
      o_changed <= 1'b0;
      o_err     <= 1'b0;
      o_rd_dat  <= 8'h00;
      for (int i = 0; i < SLOTS; i++) line_mem[i] <= 8'h00;
    end else if (i_sclr) begin
      state     <= IDLE;
      len_q     <= '0;
      cur_q     <= '0;
      idx_q     <= '0;
      o_changed <= 1'b0;
      o_err     <= 1'b0;
      o_rd_dat  <= 8'h00;
      for (int i = 0; i < SLOTS; i++) line_mem[i] <= 8'h00;
    end else begin
      o_changed <= 1'b0;
      o_rd_dat  <= rd_ok ? line_mem[i_rd_addr] : 8'h00;
      if (drop) o_err <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_ins && !o_full) begin
              idx_q <= len_q;
              state <= SHIFT_R;
            end else if (is_bs && cur_q != '0) begin
              idx_q <= cur_q - ONE_A;
              state <= SHIFT_L;
            end else if (is_right && cur_q < len_q) begin
              cur_q     <= cur_q + ONE_A;
              o_changed <= 1'b1;
            end else if (is_left && cur_q != '0) begin
              cur_q     <= cur_q - ONE_A;
              o_changed <= 1'b1;
            end else if (is_down && cur_q != '0) begin
              line_mem[cur_q - ONE_A] <= (down_src == 8'h5A) ? 8'h41 : down_src + 8'd1;
              o_changed <= 1'b1;
            end
          end
        end
        SHIFT_R: begin
          if (idx_q > cur_q) begin
            line_mem[idx_q] <= line_mem[idx_q - ONE_A];
            idx_q           <= idx_q - ONE_A;
          end else begin
            line_mem[cur_q] <= 8'h41;
            len_q           <= len_q + ONE_A;
            cur_q           <= cur_q + ONE_A;
            o_changed       <= 1'b1;
            state           <= IDLE;
          end
        end
        SHIFT_L: begin
          // The vacated tail slot is cleared so unused positions read as zero.
          if (idx_q < len_q - ONE_A) begin
            line_mem[idx_q] <= line_mem[idx_q + ONE_A];
            idx_q           <= idx_q + ONE_A;
          end else begin
            line_mem[len_q - ONE_A] <= 8'h00;
            len_q                   <= len_q - ONE_A;
            cur_q                   <= cur_q - ONE_A;
            o_changed               <= 1'b1;
            state                   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_string_buffer.sv
// Randomised scoreboard bench for string_buffer against a queue-based line model.
// Commit pulses are checked by a monitor; busy time, reads and resets by the stimulus tasks.
module tb_string_buffer;
  localparam int DEPTH = 16;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n, sclr, en, typ;
  logic [7:0]    code;
  logic [AW-1:0] rd_addr;
  logic [7:0]    o_rd_dat;
  logic [AW-1:0] o_len, o_cursor;
  logic          o_ready, o_full, o_changed, o_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] model_q[$];
  int         m_cur;
  bit         m_err;

  typedef struct {int len; int cur;} exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  string_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_sclr(sclr), .i_asciiex(code),
    .i_asciiex_en(en), .i_type(typ), .i_rd_addr(rd_addr), .o_rd_dat(o_rd_dat),
    .o_len(o_len), .o_cursor(o_cursor), .o_ready(o_ready), .o_full(o_full),
    .o_changed(o_changed), .o_err(o_err)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
    end
  endtask

  // Monitor: every commit pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (o_changed === 1'b1) begin
      if (exp_q.size() == 0) checkOutput("unexpected_changed", o_changed, 0);
      else begin
        e = exp_q.pop_front();
        checkOutput("changed_len", o_len, e.len);
        checkOutput("changed_cursor", o_cursor, e.cur);
      end
    end
  end

  function automatic void pushExp();
    exp_t e;
    e.len = model_q.size();
    e.cur = m_cur;
    exp_q.push_back(e);
  endfunction

  function automatic void modelReset();
    model_q.delete();
    exp_q.delete();
    m_cur = 0;
    m_err = 0;
  endfunction

  task automatic applyStimulus(input logic [7:0] c, input logic t, input bit overlap);
    int L, busy, cnt;
    bit ok;
    L    = model_q.size();
    busy = 0;
    ok   = ((c == 8'h41 || c == 8'h08) && t) || ((c == 8'h02 || c == 8'h03 || c == 8'h04) && !t);
    if (!ok) m_err = 1;
    else begin
      case (c)
        8'h41: if (L < DEPTH) begin busy = L - m_cur + 1; model_q.insert(m_cur, 8'h41); m_cur++; pushExp(); end
        8'h08: if (m_cur > 0) begin busy = L - m_cur + 1; model_q.delete(m_cur - 1); m_cur--; pushExp(); end
        8'h02: if (m_cur < L) begin m_cur++; pushExp(); end
        8'h04: if (m_cur > 0) begin m_cur--; pushExp(); end
        8'h03: if (m_cur > 0) begin
          model_q[m_cur-1] = (model_q[m_cur-1] == 8'h5A) ? 8'h41 : model_q[m_cur-1] + 8'd1;
          pushExp();
        end
        default: ;
      endcase
    end
    @(negedge clk); code = c; typ = t; en = 1'b1;
    @(negedge clk); en = 1'b0;
    cnt = 0;
    while (!o_ready && cnt < 40) begin
      if (overlap && cnt == 0 && busy > 0) begin
        code = 8'h04; typ = 1'b0; en = 1'b1; m_err = 1;
      end else en = 1'b0;
      cnt++;
      @(negedge clk);
    end
    en = 1'b0;
    if (cnt >= 40) checkOutput("ready_timeout", o_ready, 1);
    checkOutput("busy_cycles", cnt, busy);
    @(negedge clk);
    checkOutput("len", o_len, model_q.size());
    checkOutput("cursor", o_cursor, m_cur);
    checkOutput("err", o_err, m_err);
  endtask

  task automatic checkLine();
    for (int a = 0; a < DEPTH + 2; a++) begin
      int ex;
      @(negedge clk); rd_addr = (a <= DEPTH) ? AW'(a) : AW'(2**AW - 1);
      @(negedge clk);
      ex = (a < model_q.size()) ? int'(model_q[a]) : 0;
      checkOutput("rd_dat", o_rd_dat, ex);
    end
    checkOutput("full", o_full, model_q.size() == DEPTH);
    checkOutput("pending_changed", exp_q.size(), 0);
    checkOutput("line_len", o_len, model_q.size());
    checkOutput("line_err", o_err, m_err);
  endtask

  task automatic checkReset();
    checkOutput("rst_len", o_len, 0);
    checkOutput("rst_cursor", o_cursor, 0);
    checkOutput("rst_ready", o_ready, 1);
    checkOutput("rst_changed", o_changed, 0);
    checkOutput("rst_err", o_err, 0);
    checkOutput("rst_full", o_full, 0);
    checkOutput("rst_rd_dat", o_rd_dat, 0);
  endtask

  task automatic abortTest(input logic [7:0] c, input logic t, input bit async_rst);
    @(negedge clk); code = c; typ = t; en = 1'b1;
    @(negedge clk); en = 1'b0;
    checkOutput("busy_pre_abort", o_ready, 0);
    @(negedge clk);
    if (async_rst) begin
      rst_n = 1'b0; #1;
      checkReset();
      @(negedge clk); rst_n = 1'b1;
    end else begin
      sclr = 1'b1;
      @(negedge clk);
      checkReset();
      sclr = 1'b0;
    end
    modelReset();
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; sclr = 1'b0; en = 1'b0; typ = 1'b0; code = 8'h00; rd_addr = '0;
    modelReset();
    repeat (3) @(negedge clk);
    checkReset();
    rst_n = 1'b1;
    checkLine();

    // Three inserts build "AAA".
    repeat (3) begin
      applyStimulus(8'h41, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
    end
    checkLine();

    // Navigation and the Z->A wrap of the down key.
    repeat (2) applyStimulus(8'h04, 1'b0, 1'b0);
    repeat (2) applyStimulus(8'h03, 1'b0, 1'b0);
    checkLine();
    repeat (24) applyStimulus(8'h03, 1'b0, 1'b0);
    checkLine();

    // "CAB" with cursor 1, then insert and backspace in the middle.
    repeat (2) applyStimulus(8'h03, 1'b0, 1'b0);
    repeat (2) applyStimulus(8'h02, 1'b0, 1'b0);
    applyStimulus(8'h03, 1'b0, 1'b0);
    repeat (2) applyStimulus(8'h04, 1'b0, 1'b0);
    checkLine();
    applyStimulus(8'h41, 1'b1, 1'b0);
    checkLine();
    applyStimulus(8'h08, 1'b1, 1'b0);
    checkLine();

    // Dropped events: busy, unknown code, wrong class.
    applyStimulus(8'h41, 1'b1, 1'b1);
    applyStimulus(8'h07, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b1, 1'b0);
    applyStimulus(8'h08, 1'b0, 1'b0);
    checkLine();

    // Full line and edge no-ops.
    while (model_q.size() < DEPTH) applyStimulus(8'h41, 1'b1, 1'b0);
    checkLine();
    applyStimulus(8'h41, 1'b1, 1'b0);
    while (m_cur > 0) applyStimulus(8'h04, 1'b0, 1'b0);
    applyStimulus(8'h08, 1'b1, 1'b0);
    applyStimulus(8'h04, 1'b0, 1'b0);
    while (m_cur < model_q.size()) applyStimulus(8'h02, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0);
    checkLine();

    // Synchronous clear during a right shift, async reset during a left shift.
    applyStimulus(8'h08, 1'b1, 1'b0);
    while (m_cur > 2) applyStimulus(8'h04, 1'b0, 1'b0);
    abortTest(8'h41, 1'b1, 1'b0);
    checkLine();
    repeat (6) applyStimulus(8'h41, 1'b1, 1'b0);
    while (m_cur > 1) applyStimulus(8'h04, 1'b0, 1'b0);
    abortTest(8'h08, 1'b1, 1'b1);
    checkLine();

    for (int n = 0; n < 250; n++) begin
      int r;
      r = $urandom_range(0, 10);
      case (r)
        0, 1, 2, 3: applyStimulus(8'h41, 1'b1, 1'b0);
        4, 5:       applyStimulus(8'h08, 1'b1, 1'b0);
        6:          applyStimulus(8'h02, 1'b0, 1'b0);
        7:          applyStimulus(8'h04, 1'b0, 1'b0);
        8:          applyStimulus(8'h03, 1'b0, 1'b0);
        9:          applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        default:    applyStimulus(8'h41, 1'b1, 1'b1);
      endcase
      if (n % 50 == 49) checkLine();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/string_buffer.md
Name: string_buffer

Overview:
- Edit-buffer stage directly downstream of the key-input block.
- Consumes the one-cycle extended-ASCII key events and maintains a fixed-depth character line with a cursor.
- Supports insert-'A', backspace, cursor left/right, and "down" (increment the character before the cursor, 'A'..'Z').
- Insert and delete shift the line serially, one position per cycle, behind a ready flag.
- Provides a registered read port for the display/serializer stage.

Parameters:
- DEPTH, 16, line capacity in characters.
- AW, 5, width of cursor, length and read address; must satisfy 2^AW > DEPTH.

Ports:
- clk  in  1  system clock
- i_rst_n  in  1  reset: asynchronous, active-low
- i_sclr  in  1  synchronous clear; same effect as reset
- i_asciiex  in  8  event code: 0x41 char, 0x08 backspace, 0x02 right, 0x03 down, 0x04 left
- i_asciiex_en  in  1  one-cycle event strobe
- i_type  in  1  1 = edit event (0x41/0x08), 0 = navigation event (0x02/0x03/0x04)
- i_rd_addr  in  AW  display read address
- o_rd_dat  out  8  char at i_rd_addr; registered, 1-cycle latency
- o_len  out  AW  number of valid chars, 0..DEPTH
- o_cursor  out  AW  cursor position, 0..o_len
- o_ready  out  1  high = an event is accepted this cycle
- o_full  out  1  o_len == DEPTH (combinational from o_len)
- o_changed  out  1  one-cycle pulse when buffer or cursor is committed
- o_err  out  1  sticky: event dropped (busy, unknown code, or type mismatch)

Behaviour:
- Reset / i_sclr (i_sclr has priority over all activity and aborts any shift):
  - all DEPTH entries = 0x00; o_len = 0; o_cursor = 0
  - o_ready = 1; o_changed = 0; o_err = 0; o_rd_dat = 0x00; FSM = IDLE
- Unused positions (>= o_len) always hold 0x00.
- Accept rule: event is accepted iff i_asciiex_en & o_ready & known code & i_type matches the code class.
  - i_asciiex_en with o_ready=0, unknown code, or type mismatch: event dropped, o_err <= 1, no state change.
- FSM states: IDLE, SHIFT_R, SHIFT_L. o_ready = (state == IDLE).
- 0x41 insert, cursor c, length L:
  - L == DEPTH: ignored silently, no o_err, no o_changed.
  - Otherwise idx <= L and go to SHIFT_R.
  - In SHIFT_R, each cycle with idx > c: buf[idx] <= buf[idx-1]; idx--.
  - When idx == c: buf[c] <= 0x41; len++; cursor++; o_changed pulse; return to IDLE.
  - Busy time is (L - c) + 1 cycles after the accept cycle.
- 0x08 backspace:
  - c == 0: ignored silently.
  - Otherwise idx <= c-1 and go to SHIFT_L.
  - In SHIFT_L, each cycle with idx < L-1: buf[idx] <= buf[idx+1]; idx++.
  - When idx == L-1: buf[L-1] <= 0x00; len--; cursor--; o_changed pulse; IDLE.
  - Busy time is (L - c) + 1 cycles.
- 0x02 right: if c < L then c++ and o_changed pulse, else no-op. Completes in the accept cycle; o_ready stays high.
- 0x04 left: if c > 0 then c-- and o_changed pulse, else no-op. Single cycle.
- 0x03 down: if c > 0, buf[c-1] <= (buf[c-1] == 0x5A) ? 0x41 : buf[c-1]+1, with o_changed pulse; if c == 0, no-op. Single cycle.
- Read port: o_rd_dat <= (i_rd_addr < DEPTH) ? buf[i_rd_addr] : 0x00, every cycle including while busy. Shifts in progress are visible.
- o_err is cleared only by reset or i_sclr.
- o_changed fires exactly once per committed operation and never for no-ops.
- Asynchronous reset mid-shift: immediate return to the reset state; partial shift contents are discarded.

Test Plan:
- Reset, then 3x (0x41, type 1) spaced 4 cycles -> o_len=3, o_cursor=3, addrs 0..2 read 0x41 one cycle after address, addr 3 reads 0x00, 3 o_changed pulses.
- From "AAA" cursor 3: left, left (cursor=1), down x2 -> buf[0]=0x43. Then down x24 more -> buf[0] wraps 0x5A -> 0x41.
- Build "CAB" (cursor=1), insert -> o_ready low exactly 3 cycles, line "CAAB", cursor=2. Backspace -> o_ready low 3 cycles, line "CAB", cursor=1, buf[3]=0x00.
- Fill to DEPTH=16 -> o_full=1; a further insert gives no change, no o_changed, o_err=0. Backspace at cursor 0 -> no-op. Right at cursor=len -> no-op.
- Event strobe during SHIFT_R, code 0x07, or 0x02 with i_type=1 -> dropped, o_err=1 sticky until i_sclr; buffer unaffected.
- Assert i_rst_n=0 mid SHIFT_L, and separately i_sclr mid SHIFT_R -> all outputs at reset values next edge (async: immediately), o_ready=1.
